arb_requester: RTL and testbench
================================

// Module: arb_requester
// PURPOSE
//  Requester-side agent for the fixed-priority req/gnt arbiter: one instance per arbiter port.
//  - Buffers local transfers in a small FIFO and raises req_o while any entry is pending.
//  - Issues one buffered word per grant onto the shared output bus.
//  - Flags starvation when a request waits too long without a grant.
// PARAMETERS
//  DATA_W        8   width of a buffered transfer word
//  DEPTH         4   FIFO entries; power of two, >= 2
//  STARVE_LIMIT  15  consecutive ungranted request cycles before starve_o asserts; >= 1
// PORTS
//  clk_i        in   1                   clock, rising edge
//  rst_ni       in   1                   reset, asynchronous assert, active-low
//  in_valid_i   in   1                   local producer has a word
//  in_data_i    in   DATA_W              local producer word
//  in_ready_o   out  1                   FIFO can accept; push = in_valid_i & in_ready_o
//  req_o        out  1                   request to arbiter (to arbiter req_i[n])
//  gnt_i        in   1                   grant from arbiter (from arbiter gnt_o[n])
//  out_valid_o  out  1                   granted word valid on shared bus, 1-cycle pulse
//  out_data_o   out  DATA_W              granted word
//  starve_o     out  1                   request pending >= STARVE_LIMIT cycles with no grant
//  level_o      out  $clog2(DEPTH)+1     current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_ni=0, any time, mid-transfer included):
//  - FIFO flushed; pointers, count and starve counter are 0.
//  - req_o=0, out_valid_o=0, out_data_o=0, starve_o=0, level_o=0, in_ready_o=1.
//  - All in-flight words are discarded.
//  FIFO:
//  - in_ready_o = (level != DEPTH), driven from registered count only.
//  - A push in the same cycle as a pop while full is refused: no combinational ready from gnt_i.
//  - Pointers wrap modulo DEPTH.
//  - level_o updates on the edge: +1 on push only, -1 on pop only, unchanged on push+pop.
//  Request:
//  - req_o = (level != 0), from registered state only. No combinational path from gnt_i to req_o.
//  Grant:
//  - Pop = gnt_i & req_o, sampled at the rising edge.
//  - Next cycle: out_valid_o=1 and out_data_o = popped head word (1-cycle latency, registered).
//  - With back-to-back grants, one word issues per cycle; out_valid_o stays high continuously.
//  - gnt_i while req_o=0 is ignored: no pop, no out_valid_o.
//  - Push into an empty FIFO raises req_o the following cycle. A grant in the push cycle is ignored.
//  - out_data_o holds its last value when out_valid_o=0.
//  Starvation counter (width $clog2(STARVE_LIMIT+1)):
//  - Increments each cycle req_o & ~gnt_i, saturating at STARVE_LIMIT.
//  - Clears to 0 on any cycle with a pop, or when req_o=0.
//  - starve_o = (counter == STARVE_LIMIT), registered.
//  - starve_o drops the cycle after the clearing grant.
//  Arithmetic: all counts unsigned; no overflow possible by construction.
// STRUCTURE
//  - Package arb_pkg: localparam defaults (ARB_DATA_W, ARB_DEPTH, ARB_STARVE_LIMIT).
//  - arb_pkg also holds a helper function clog2_min1 (returns >= 1) used for pointer and counter widths.
//  - Sub-module arb_req_fifo: sync FIFO with push/pop/full/empty/level.
//  - Top level holds the req/gnt logic, the output register and the starve counter.
// TESTING
//  1. Reset: hold rst_ni=0 with in_valid_i=1 -> req_o=0, level_o=0, in_ready_o=1, out_valid_o=0.
//  2. Single word: push 0xA5, gnt_i=1 the first cycle req_o=1 -> next cycle out_valid_o=1,
//     out_data_o=0xA5; then req_o=0.
//  3. Fill and drain (DEPTH=4): push 0x01..0x04 -> in_ready_o=0, level_o=4.
//     Hold gnt_i=1 -> 4 consecutive out_valid_o pulses 0x01..0x04 in order.
//     In the last cycle of that run, req_o=0.
//  4. Full push+pop: when full, push attempt plus grant -> push refused, level_o=3.
//     Then push 0x05 -> accepted; wrap-around order preserved.
//  5. Starvation: 1 word pending, gnt_i=0 for 15 cycles -> starve_o=1 from cycle 15, held.
//     gnt_i=1 -> starve_o=0 the next cycle; a spurious gnt_i while empty -> no output.
//  6. Mid-op reset: 3 words queued, grant in flight, rst_ni pulsed low asynchronously ->
//     all outputs 0 immediately; no out_valid_o after release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared defaults and width helper for the arbiter requester agent.
package arb_pkg;

    localparam int ARB_DATA_W       = 8;
    localparam int ARB_DEPTH        = 4;
    localparam int ARB_STARVE_LIMIT = 15;

    // Bit width needed to index 'value' states, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = $clog2(value);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/arb_requester_if.sv
// Local-producer, arbiter handshake and shared-bus signals of one requester port.
interface arb_requester_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              req_o;
    logic              gnt_i;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              starve_o;
    logic [LVL_W-1:0]  level_o;

    // Requester side (the design)
    modport slave (
        input  in_valid_i, in_data_i, gnt_i,
        output in_ready_o, req_o, out_valid_o, out_data_o, starve_o, level_o
    );

    // Producer/arbiter side (the environment)
    modport master (
        output in_valid_i, in_data_i, gnt_i,
        input  in_ready_o, req_o, out_valid_o, out_data_o, starve_o, level_o
    );
endinterface

// File: rtl/arb_req_fifo.sv
// Synchronous FIFO buffering local words until the arbiter grants them.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int DEPTH  = ARB_DEPTH,
    localparam int PTR_W = clog2_min1(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  count_r;
    logic              push_s;
    logic              pop_s;

    assign full_o  = (count_r == LVL_W'(DEPTH));
    assign empty_o = (count_r == {LVL_W{1'b0}});
    assign level_o = count_r;
    assign rdata_o = mem_r[rd_ptr_r];
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;

    // Storage, power-of-two pointers (wrap by overflow) and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata_i;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LVL_W'(1);
                2'b01:   count_r <= count_r - LVL_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Requester agent: buffers local words, requests the arbiter, issues one word per grant
// and flags starvation.
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W       = ARB_DATA_W,
    parameter int DEPTH        = ARB_DEPTH,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    arb_requester_if.slave  bus
);

    localparam int STARVE_W = clog2_min1(STARVE_LIMIT + 1);
    localparam int LVL_W    = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]   head_s;
    logic                full_s;
    logic                empty_s;
    logic [LVL_W-1:0]    level_s;
    logic                req_s;
    logic                push_s;
    logic                pop_s;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic [STARVE_W-1:0] starve_cnt_nxt_s;
    logic                starve_r;

    // Ready and request depend only on the registered count, never on gnt_i.
    assign req_s  = ~empty_s;
    assign push_s = bus.in_valid_i & ~full_s;
    assign pop_s  = bus.gnt_i & req_s;

    arb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (bus.in_data_i),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_s)
    );

    // Starvation counter: clears on a pop or idle, saturates at the limit.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (pop_s || !req_s) begin
            starve_cnt_nxt_s = {STARVE_W{1'b0}};
        end else if (starve_cnt_r != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_nxt_s = starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // Output register (data held between pulses) and starvation state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_W{1'b0}};
            starve_cnt_r <= {STARVE_W{1'b0}};
            starve_r     <= 1'b0;
        end else begin
            out_valid_r  <= pop_s;
            if (pop_s) begin
                out_data_r <= head_s;
            end
            starve_cnt_r <= starve_cnt_nxt_s;
            starve_r     <= (starve_cnt_nxt_s == STARVE_W'(STARVE_LIMIT));
        end
    end

    assign bus.in_ready_o  = ~full_s;
    assign bus.req_o       = req_s;
    assign bus.out_valid_o = out_valid_r;
    assign bus.out_data_o  = out_data_r;
    assign bus.starve_o    = starve_r;
    assign bus.level_o     = level_s;

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: vector table, reference FIFO model feeding an
// output scoreboard, and hand-written starvation and mid-operation reset sequences.
module tb_arb_requester;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LIMIT = 15;

    logic clk;
    logic rst_n;

    arb_requester_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    arb_requester #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          g;
        logic          req;
        logic          rdy;
        logic [2:0]    lvl;
        logic          ov;
        logic [DW-1:0] od;
        logic          st;
    } vec_t;

    int n_vec;
    int n_bad;
    logic [DW-1:0] mq[$];   // reference FIFO contents
    logic [DW-1:0] sb[$];   // words expected on the output bus, in order

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance the model, sample 1 time unit after posedge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic g);
        logic pop_m;
        logic push_m;
        @(negedge clk);
        bus.in_valid_i = v;
        bus.in_data_i  = d;
        bus.gnt_i      = g;
        pop_m  = g && (mq.size() != 0);
        push_m = v && (mq.size() != DEPTH);
        if (pop_m) begin
            sb.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (push_m) mq.push_back(d);
        @(posedge clk);
        #1;
        if (bus.out_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'(bus.out_data_o), 32'hDEAD_BEEF);
            end else begin
                chk("sb_out_data", 32'(bus.out_data_o), 32'(sb[0]));
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic rdy,
                           input logic [2:0] lvl, input logic ov, input logic [DW-1:0] od,
                           input logic st);
        chk({tag, ".req"},   32'(bus.req_o),       32'(req));
        chk({tag, ".ready"}, 32'(bus.in_ready_o),  32'(rdy));
        chk({tag, ".level"}, 32'(bus.level_o),     32'(lvl));
        chk({tag, ".ovld"},  32'(bus.out_valid_o), 32'(ov));
        chk({tag, ".odata"}, 32'(bus.out_data_o),  32'(od));
        chk({tag, ".starve"},32'(bus.starve_o),    32'(st));
    endtask

    vec_t vt[$];

    initial begin
        n_vec = 0;
        n_bad = 0;
        //            v     d      g     req   rdy   lvl   ov    od     st
        vt.push_back('{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0}); // push, grant ignored
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5, 1'b0}); // single issue
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b0}); // data held
        vt.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'hA5, 1'b0});
        vt.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'hA5, 1'b0});
        vt.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'hA5, 1'b0});
        vt.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 8'hA5, 1'b0}); // full
        vt.push_back('{1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 8'h01, 1'b0}); // push refused, pop
        vt.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 8'h01, 1'b0}); // wrap push
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 8'h02, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 8'h03, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 8'h04, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 8'h05, 1'b0}); // last: req low
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h05, 1'b0}); // spurious grant
        vt.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h05, 1'b0});
        vt.push_back('{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 8'h11, 1'b0}); // push+pop
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 8'h22, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h22, 1'b0});

        // Reset held with producer and grant active.
        rst_n          = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'hFF;
        bus.gnt_i      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.gnt_i      = 1'b0;
        rst_n          = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].v, vt[i].d, vt[i].g);
            chk_all($sformatf("vec%0d", i), vt[i].req, vt[i].rdy, vt[i].lvl,
                    vt[i].ov, vt[i].od, vt[i].st);
        end

        // Starvation: one pending word, never granted.
        step(1'b1, 8'h3C, 1'b0);
        chk("starve.push_req", 32'(bus.req_o), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 8'h00, 1'b0);
            chk($sformatf("starve.wait%0d", k), 32'(bus.starve_o), 32'(k >= LIMIT));
        end
        step(1'b0, 8'h00, 1'b1);
        chk_all("starve.grant", 1'b0, 1'b1, 3'd0, 1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk_all("starve.spurious", 1'b0, 1'b1, 3'd0, 1'b0, 8'h3C, 1'b0);

        // Mid-operation asynchronous reset with a grant in flight.
        step(1'b1, 8'h71, 1'b0);
        step(1'b1, 8'h72, 1'b0);
        step(1'b1, 8'h73, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk_all("midrst.pre", 1'b1, 1'b1, 3'd2, 1'b1, 8'h71, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_all("midrst.async", 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        mq.delete();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 1'b1);
            chk_all($sformatf("midrst.post%0d", k), 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
